e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the pipelined MIPS core with precise exceptions. It sits directly downstream of the D→E pipeline register and consumes the E-stage instruction class and operands (`rs`/`rt` values). It owns the architectural HI/LO registers and models multi-cycle multiply and divide latency with a busy counter. It also drives the `busy` signal that the hazard unit uses to stall HI/LO-dependent instructions in D.

---
 rtl/e_mdu_pkg.sv | 41 ++++
 rtl/e_mdu.sv | 198 +++++++++++++++++++
 tb/tb_e_mdu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_pkg
// Description : Op codes, FSM encodings, default latencies and helpers shared
//               by the execute-stage multiply/divide unit and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package e_mdu_pkg;

    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;

    localparam int c_MULT_CYCLES_DEF = 5;
    localparam int c_DIV_CYCLES_DEF  = 10;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage : e_mdu_pkg
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu
// Description : Execute-stage multiply/divide unit owning HI/LO. Results are
//               computed at issue into a shadow and committed after a fixed
//               busy latency. Define MDU_MADD_EN to enable MADD/MSUB ops 9-12.
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    hilo_t              r_shadow;

    logic        w_idle;
    logic        w_accept;
    logic        w_last;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_mul_signed;
    logic        w_div_signed;

    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic [63:0] w_mul_result;

    logic        w_num_neg;
    logic        w_den_neg;
    logic [31:0] w_num_mag;
    logic [31:0] w_den_mag;
    logic        w_den_zero;
    logic [31:0] w_den_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    hilo_t       w_div_result;

    assign w_idle   = (r_state == c_S_IDLE);
    assign w_accept = start & ~cancel & w_idle;
    assign w_last   = (r_cnt <= c_ONE);

    // Op decode; accumulate ops decode to nothing when the feature is absent
    always_comb begin
        w_is_mul     = 1'b0;
        w_is_div     = 1'b0;
        w_mul_signed = 1'b0;
        w_div_signed = 1'b0;
        case (op)
            c_OP_MULT:  begin w_is_mul = 1'b1; w_mul_signed = 1'b1; end
            c_OP_MULTU: w_is_mul = 1'b1;
            c_OP_DIV:   begin w_is_div = 1'b1; w_div_signed = 1'b1; end
            c_OP_DIVU:  w_is_div = 1'b1;
`ifdef MDU_MADD_EN
            c_OP_MADD:  begin w_is_mul = 1'b1; w_mul_signed = 1'b1; end
            c_OP_MADDU: w_is_mul = 1'b1;
            c_OP_MSUB:  begin w_is_mul = 1'b1; w_mul_signed = 1'b1; end
            c_OP_MSUBU: w_is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    assign w_ma   = {{32{w_mul_signed & rs[31]}}, rs};
    assign w_mb   = {{32{w_mul_signed & rt[31]}}, rt};
    assign w_prod = w_ma * w_mb;

`ifdef MDU_MADD_EN
    logic [63:0] w_hilo;
    assign w_hilo = {r_hi, r_lo};

    always_comb begin
        w_mul_result = w_prod;
        case (op)
            c_OP_MADD, c_OP_MADDU: w_mul_result = w_hilo + w_prod;
            c_OP_MSUB, c_OP_MSUBU: w_mul_result = w_hilo - w_prod;
            default: ;
        endcase
    end
`else
    assign w_mul_result = w_prod;
`endif

    // Sign-magnitude divide; MIN/-1 falls out naturally as 0x80000000 rem 0
    assign w_num_neg  = w_div_signed & rs[31];
    assign w_den_neg  = w_div_signed & rt[31];
    assign w_num_mag  = cond_neg(rs, w_num_neg);
    assign w_den_mag  = cond_neg(rt, w_den_neg);
    assign w_den_zero = (rt == 32'd0);
    assign w_den_safe = w_den_zero ? 32'd1 : w_den_mag;
    assign w_q_mag    = w_num_mag / w_den_safe;
    assign w_r_mag    = w_num_mag % w_den_safe;

    // Divide by zero commits the current HI/LO back, i.e. leaves them intact
    always_comb begin
        if (w_den_zero) begin
            w_div_result.hi = r_hi;
            w_div_result.lo = r_lo;
        end else begin
            w_div_result.hi = cond_neg(w_r_mag, w_num_neg);
            w_div_result.lo = cond_neg(w_q_mag, w_num_neg ^ w_den_neg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = c_S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_state_next = c_S_DIV;
                end
            end
            c_S_MUL, c_S_DIV: begin
                if (w_last) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy  = ~w_idle;
        rdata = 32'd0;
        if (op == c_OP_MFHI) begin
            rdata = r_hi;
        end else if (op == c_OP_MFLO) begin
            rdata = r_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_shadow <= '0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_shadow <= w_mul_result;
                r_cnt    <= c_MUL_LOAD;
            end else if (w_is_div) begin
                r_shadow <= w_div_result;
                r_cnt    <= c_DIV_LOAD;
            end else if (op == c_OP_MTHI) begin
                r_hi <= rs;
            end else if (op == c_OP_MTLO) begin
                r_lo <= rs;
            end
        end else if (!w_idle) begin
            r_cnt <= r_cnt - c_ONE;
            if (w_last) begin
                r_hi <= r_shadow.hi;
                r_lo <= r_shadow.lo;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : e_mdu
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_e_mdu
// Description : Directed vector bench for e_mdu (follows MDU_MADD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e_mdu;
    import e_mdu_pkg::*;

`ifdef MDU_MADD_EN
    localparam bit c_MADD_EN = 1'b1;
`else
    localparam bit c_MADD_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    vec_t        vecs[15];

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int l, input logic [31:0] h, input logic [31:0] w);
        vec_t v;
        v.op = o; v.rs = a; v.rt = b; v.lat = l; v.hi = h; v.lo = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, then count busy cycles; optional pulses land on busy cycle n
    task automatic run_vec(input vec_t v, input int idx, input bit c0,
                           input int cancel_at, input int intrude_at);
        int          n;
        logic [31:0] hi_b;
        logic [31:0] lo_b;
        @(negedge clk);
        op = v.op; rs = v.rs; rt = v.rt; start = 1'b1; cancel = c0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = c_OP_NONE; rs = 32'd0; rt = 32'd0;
        hi_b = hi;
        lo_b = lo;
        n = 0;
        while (busy && n < 60) begin
            n++;
            start  = (n == intrude_at);
            cancel = (n == cancel_at);
            op     = (n == intrude_at) ? c_OP_MTHI : c_OP_NONE;
            rs     = 32'h0000DEAD;
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0; op = c_OP_NONE; rs = 32'd0;
        chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.lat));
        if (v.lat > 0) begin
            chk($sformatf("v%0d hi_stale", idx), hi_b, m_hi);
            chk($sformatf("v%0d lo_stale", idx), lo_b, m_lo);
        end
        chk($sformatf("v%0d hi", idx), hi, v.hi);
        chk($sformatf("v%0d lo", idx), lo, v.lo);
        op = c_OP_MFHI; #1;
        chk($sformatf("v%0d rdata_mfhi", idx), rdata, v.hi);
        op = c_OP_MFLO; #1;
        chk($sformatf("v%0d rdata_mflo", idx), rdata, v.lo);
        op = c_OP_NONE; #1;
        chk($sformatf("v%0d rdata_none", idx), rdata, 32'd0);
        m_hi = v.hi;
        m_lo = v.lo;
    endtask

    initial begin
        vecs[0]  = mk(c_OP_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        vecs[1]  = mk(c_OP_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        vecs[2]  = mk(c_OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        vecs[3]  = mk(c_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        vecs[4]  = mk(c_OP_DIVU,  32'd5, 32'd0, 10, 32'h0, 32'h80000000);
        vecs[5]  = mk(c_OP_MTHI,  32'h1234, 32'd0, 0, 32'h1234, 32'h80000000);
        vecs[6]  = mk(c_OP_MTLO,  32'hFFFFFFFF, 32'd0, 0, 32'h1234, 32'hFFFFFFFF);
        vecs[7]  = mk(c_OP_MTHI,  32'h0, 32'd0, 0, 32'h0, 32'hFFFFFFFF);
        vecs[8]  = mk(c_OP_MADDU, 32'd1, 32'd1, c_MADD_EN ? 5 : 0,
                      c_MADD_EN ? 32'h1 : 32'h0, c_MADD_EN ? 32'h0 : 32'hFFFFFFFF);
        vecs[9]  = mk(c_OP_MSUB,  32'd2, 32'd3, c_MADD_EN ? 5 : 0,
                      32'h0, c_MADD_EN ? 32'hFFFFFFFA : 32'hFFFFFFFF);
        vecs[10] = mk(c_OP_DIVU,  32'hFFFFFFFF, 32'h10, 10, 32'hF, 32'h0FFFFFFF);
        vecs[11] = mk(c_OP_MULT,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0);
        vecs[12] = mk(c_OP_MADD,  32'hFFFFFFFF, 32'd1, c_MADD_EN ? 5 : 0,
                      c_MADD_EN ? 32'h3FFFFFFF : 32'h40000000,
                      c_MADD_EN ? 32'hFFFFFFFF : 32'h0);
        vecs[13] = mk(c_OP_MTHI,  32'h1111, 32'd0, 0, 32'h1111,
                      c_MADD_EN ? 32'hFFFFFFFF : 32'h0);
        vecs[14] = mk(c_OP_MTLO,  32'h2222, 32'd0, 0, 32'h1111, 32'h2222);

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = c_OP_NONE; rs = 32'd0; rt = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset rdata", rdata, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i, 1'b0, -1, -1);

        // start together with cancel: nothing may change, not even MTLO
        run_vec(mk(c_OP_MTLO, 32'hAAAA, 32'd0, 0, 32'h1111, 32'h2222), 100, 1'b1, -1, -1);
        run_vec(mk(c_OP_MULT, 32'd7, 32'd7, 0, 32'h1111, 32'h2222), 101, 1'b1, -1, -1);
        // cancel while busy: in-flight op still commits
        run_vec(mk(c_OP_MULT, 32'd3, 32'd4, 5, 32'h0, 32'd12), 102, 1'b0, 2, -1);
        // start while busy is ignored and does not extend latency
        run_vec(mk(c_OP_MULTU, 32'd2, 32'd2, 5, 32'h0, 32'd4), 103, 1'b0, -1, 3);
        run_vec(mk(c_OP_DIV, 32'd100, 32'hFFFFFFF9, 10, 32'd2, 32'hFFFFFFF2), 104, 1'b0, -1, 4);

        // reset in the middle of a multiply drops it
        @(negedge clk);
        op = c_OP_MULT; rs = 32'd5; rt = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = c_OP_NONE;
        chk("mid busy before reset", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        chk("post reset busy", 32'(busy), 32'd0);
        chk("post reset hi", hi, 32'd0);
        chk("post reset lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_e_mdu
`default_nettype wire
